// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: turns set/reset/toggle commands into exclusive s/r pulses followed by a quiet gap.
// Optional macro SR_TOGGLE_EN enables TOGGLE; without it TOGGLE is accepted as a NOP and flags err.
module sr_cmd_sequencer #(
  parameter int WIDTH        = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             err
);
  localparam int MX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES > 1 ? GAP_CYCLES - 2 : 0);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] s_n, r_n, shadow_n, s_drv, r_drv;
  logic err_n, bad, go;
`ifdef SR_TOGGLE_EN
  assign s_drv = req_op == 2'b01 ? req_mask : req_op == 2'b11 ? req_mask & ~shadow_q : '0;
  assign r_drv = req_op == 2'b10 ? req_mask : req_op == 2'b11 ? req_mask & shadow_q : '0;
  assign bad   = 1'b0;
`else
  assign s_drv = req_op == 2'b01 ? req_mask : '0;
  assign r_drv = req_op == 2'b10 ? req_mask : '0;
  assign bad   = req_op == 2'b11;
`endif
  assign req_ready = state == IDLE;
  assign busy      = !req_ready;
  // NOP, zero mask and disabled TOGGLE all produce no pulse, so they finish in IDLE
  assign go        = req_valid && req_ready && |(s_drv | r_drv);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    s_n      = s;
    r_n      = r;
    shadow_n = shadow_q;
    err_n    = 1'b0;
    if (state == IDLE) begin
      err_n = req_valid && bad;
      if (go) begin
        state_n = DRIVE;
        cnt_n   = '0;
        s_n     = s_drv;
        r_n     = r_drv;
      end
    end else if (state == DRIVE) begin
      cnt_n = cnt + CW'(1);
      if (cnt == P_LAST) begin
        // the final gap cycle is spent in IDLE so back-to-back commands keep the full gap
        state_n  = GAP_CYCLES > 1 ? GAP : IDLE;
        cnt_n    = '0;
        s_n      = '0;
        r_n      = '0;
        shadow_n = (shadow_q & ~r) | s;
      end
    end else begin
      cnt_n = cnt + CW'(1);
      if (cnt == G_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s        <= '0;
      r        <= '0;
      shadow_q <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      s        <= s_n;
      r        <= r_n;
      shadow_q <= shadow_n;
      err      <= err_n;
    end
  end
endmodule
